// File: rtl/inst_mem_loader.sv
// Instruction memory loader: packs a host byte stream into 32-bit
// big-endian words, writes them into one process slot of the instruction
// memory, and checks a trailing XOR checksum byte.
module inst_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int SLOT_WORDS = 1024,
  parameter int NUM_SLOTS  = 2,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int WC_W      = $clog2(SLOT_WORDS) + 1
) (
  input  logic                  Fast_Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [SLOT_W-1:0]     Slot,
  input  logic [WC_W-1:0]       Word_Count,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Mem_Write_En,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                state_p0;
  logic [SLOT_W-1:0]     slot_p0;
  logic [WC_W-1:0]       count_p0;
  logic [WC_W-1:0]       word_idx_p0;
  logic [1:0]            byte_idx_p0;
  logic [DATA_WIDTH-1:0] shift_p0;
  logic [7:0]            cksum_p0;
  logic                  xfer;

  // A request is unusable if it names a slot that does not exist or asks
  // for zero words / more words than a slot holds.
  function automatic logic request_bad(input logic [SLOT_W-1:0] s,
                                       input logic [WC_W-1:0]   wc);
    request_bad = (32'(s) >= 32'(NUM_SLOTS)) || (wc == '0) ||
                  (32'(wc) > 32'(SLOT_WORDS));
  endfunction

  // Slot base plus word offset; wraps to the memory address width.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [SLOT_W-1:0] s,
                                                      input logic [WC_W-1:0]   w);
    logic [31:0] full;
    full      = 32'(s) * 32'(SLOT_WORDS) + 32'(w);
    word_addr = full[ADDR_WIDTH-1:0];
  endfunction

  assign xfer = Byte_Valid && Byte_Ready;

  // Load sequencer: all outputs are registered alongside the state.
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_p0       <= S_IDLE;
      slot_p0        <= '0;
      count_p0       <= '0;
      word_idx_p0    <= '0;
      byte_idx_p0    <= '0;
      shift_p0       <= '0;
      cksum_p0       <= '0;
      Byte_Ready     <= 1'b0;
      Mem_Write_En   <= 1'b0;
      Mem_Address    <= '0;
      Mem_Write_Data <= '0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Error          <= 1'b0;
    end else begin
      Mem_Write_En <= 1'b0;
      Done         <= 1'b0;
      case (state_p0)
        S_IDLE: begin
          if (Start) begin
            slot_p0     <= Slot;
            count_p0    <= Word_Count;
            word_idx_p0 <= '0;
            byte_idx_p0 <= '0;
            cksum_p0    <= '0;
            Error       <= 1'b0;
            if (request_bad(Slot, Word_Count)) begin
              // Rejected requests go straight to the completion pulse.
              state_p0 <= S_FINISH;
              Error    <= 1'b1;
              Done     <= 1'b1;
              Busy     <= 1'b0;
            end else begin
              state_p0   <= S_RECV;
              Byte_Ready <= 1'b1;
              Busy       <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (xfer) begin
            shift_p0    <= {shift_p0[DATA_WIDTH-9:0], Byte_In};
            cksum_p0    <= cksum_p0 ^ Byte_In;
            byte_idx_p0 <= byte_idx_p0 + 2'd1;
            if (byte_idx_p0 == 2'd3) begin
              state_p0       <= S_WRITE;
              Byte_Ready     <= 1'b0;
              Mem_Write_En   <= 1'b1;
              Mem_Write_Data <= {shift_p0[DATA_WIDTH-9:0], Byte_In};
              Mem_Address    <= word_addr(slot_p0, word_idx_p0);
            end
          end
        end
        S_WRITE: begin
          Byte_Ready <= 1'b1;
          if (word_idx_p0 == count_p0 - WC_W'(1)) begin
            state_p0 <= S_CHECK;
          end else begin
            word_idx_p0 <= word_idx_p0 + WC_W'(1);
            state_p0    <= S_RECV;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            Byte_Ready <= 1'b0;
            Error      <= (Byte_In != cksum_p0);
            Done       <= 1'b1;
            Busy       <= 1'b0;
            state_p0   <= S_FINISH;
          end
        end
        S_FINISH: begin
          state_p0 <= S_IDLE;
        end
        default: begin
          state_p0   <= S_IDLE;
          Byte_Ready <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: drives program images over the byte
// handshake and checks the resulting memory writes and Done/Error status.
module tb_inst_mem_loader;

  logic        Fast_Clock = 1'b0;
  logic        Reset      = 1'b1;
  logic        Start      = 1'b0;
  logic [0:0]  Slot       = 1'b0;
  logic [10:0] Word_Count = '0;
  logic [7:0]  Byte_In    = '0;
  logic        Byte_Valid = 1'b0;
  logic        Byte_Ready;
  logic        Mem_Write_En;
  logic [12:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic        Busy;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img[$];
  logic [12:0] wa_q[$];
  logic [31:0] wd_q[$];

  inst_mem_loader dut (
    .Fast_Clock     (Fast_Clock),
    .Reset          (Reset),
    .Start          (Start),
    .Slot           (Slot),
    .Word_Count     (Word_Count),
    .Byte_In        (Byte_In),
    .Byte_Valid     (Byte_Valid),
    .Byte_Ready     (Byte_Ready),
    .Mem_Write_En   (Mem_Write_En),
    .Mem_Address    (Mem_Address),
    .Mem_Write_Data (Mem_Write_Data),
    .Busy           (Busy),
    .Done           (Done),
    .Error          (Error)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  // Record every memory write strobe seen by the memory.
  always @(negedge Fast_Clock) begin
    if (Mem_Write_En === 1'b1) begin
      wa_q.push_back(Mem_Address);
      wd_q.push_back(Mem_Write_Data);
    end
  end

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    return x;
  endfunction

  // Number of recorded writes that differ from the image placed in slot s.
  function automatic int bad_words(input logic [0:0] s);
    int n = 0;
    for (int w = 0; w < wa_q.size(); w++) begin
      if (4 * w + 3 >= img.size()) n++;
      else if (wa_q[w] !== 13'(int'(s) * 1024 + w) ||
               wd_q[w] !== {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]}) n++;
    end
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b, output bit to);
    int t = 0;
    to = 0;
    Byte_In = b;
    Byte_Valid = 1'b1;
    while (Byte_Ready !== 1'b1 && t < 50) begin
      @(negedge Fast_Clock);
      t++;
    end
    if (t >= 50) to = 1;
    else @(negedge Fast_Clock);
    Byte_Valid = 1'b0;
  endtask

  task automatic run_load(input logic [0:0] s, input logic [10:0] wc, input logic [7:0] ck,
                          input bit jitter, input bit mid_start,
                          output bit got_done, output bit got_err,
                          output bit err_at_start, output bit to);
    bit t1;
    to = 0;
    @(negedge Fast_Clock);
    wa_q.delete();
    wd_q.delete();
    Slot = s;
    Word_Count = wc;
    Start = 1'b1;
    @(negedge Fast_Clock);
    Start = 1'b0;
    err_at_start = Error;
    foreach (img[i]) begin
      if (jitter) repeat ($urandom_range(0, 2)) @(negedge Fast_Clock);
      if (mid_start && i == 5) begin
        Start = 1'b1;
        Slot = ~s;
        Word_Count = 11'd3;
        @(negedge Fast_Clock);
        Start = 1'b0;
      end
      send_byte(img[i], t1);
      to |= t1;
    end
    send_byte(ck, t1);
    to |= t1;
    got_done = Done;
    got_err = Error;
  endtask

  task automatic load_scenario1();
    img.delete();
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Fast_Clock);
    Reset = 1'b0;
    @(negedge Fast_Clock);
    checks++;
    if ({Byte_Ready, Mem_Write_En, Busy, Done, Error} !== 5'b0 ||
        Mem_Address !== 13'd0 || Mem_Write_Data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h, want all 0",
               Byte_Ready, Mem_Write_En, Busy, Done, Error, Mem_Address, Mem_Write_Data);
    end
  endtask

  task automatic test_two_words();
    bit d, e, es, to;
    int n;
    load_scenario1();
    run_load(1'b0, 11'd2, img_xor(), 0, 0, d, e, es, to);
    n = bad_words(1'b0);
    checks++;
    if (to || wa_q.size() != 2 || n != 0) begin
      errors++;
      $display("FAIL two_words_writes: got %0d writes, %0d wrong, timeout=%0b; want 2 writes 0 wrong", wa_q.size(), n, to);
    end
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL two_words_status: got done=%b err=%b, want done=1 err=0", d, e);
    end
    @(negedge Fast_Clock);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b after finish, want 0 0", Done, Busy);
    end
  endtask

  task automatic test_slot1();
    bit d, e, es, to;
    img.delete();
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1'b1, 11'd1, 8'h22, 0, 0, d, e, es, to);
    checks++;
    if (to || wa_q.size() != 1 || wa_q[0] !== 13'd1024 || wd_q[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL slot1_write: got %0d writes first=%h@%0d timeout=%0b, want DEADBEEF@1024",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'h0, (wa_q.size() > 0) ? wa_q[0] : 13'h0, to);
    end
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL slot1_status: got done=%b err=%b, want 1 0", d, e);
    end
  endtask

  task automatic test_bad_cksum();
    bit d, e, es, to;
    int n;
    load_scenario1();
    run_load(1'b0, 11'd2, img_xor() ^ 8'hFF, 0, 0, d, e, es, to);
    n = bad_words(1'b0);
    checks++;
    if (to || wa_q.size() != 2 || n != 0) begin
      errors++;
      $display("FAIL bad_cksum_writes: got %0d writes, %0d wrong; want 2 writes 0 wrong", wa_q.size(), n);
    end
    checks++;
    if (d !== 1'b1 || e !== 1'b1) begin
      errors++;
      $display("FAIL bad_cksum_status: got done=%b err=%b, want 1 1", d, e);
    end
    repeat (2) @(negedge Fast_Clock);
    checks++;
    if (Error !== 1'b1) begin
      errors++;
      $display("FAIL error_level_hold: got err=%b in idle, want 1", Error);
    end
    img.delete();
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1'b0, 11'd1, img_xor(), 0, 0, d, e, es, to);
    checks++;
    if (es !== 1'b0 || d !== 1'b1 || e !== 1'b0 || to) begin
      errors++;
      $display("FAIL error_clear_on_start: got err_after_start=%b done=%b err=%b, want 0 1 0", es, d, e);
    end
  endtask

  task automatic test_bad_count();
    logic [10:0] wcs[2];
    wcs[0] = 11'd0;
    wcs[1] = 11'd1025;
    for (int k = 0; k < 2; k++) begin
      int lat;
      bit seen, err_seen;
      @(negedge Fast_Clock);
      wa_q.delete();
      wd_q.delete();
      Slot = 1'b0;
      Word_Count = wcs[k];
      Start = 1'b1;
      lat = 0;
      seen = 0;
      err_seen = 0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge Fast_Clock);
        Start = 1'b0;
        if (!seen && Done === 1'b1) begin
          seen = 1;
          lat = c;
          err_seen = Error;
        end
      end
      checks++;
      if (!seen || lat > 2 || err_seen !== 1'b1) begin
        errors++;
        $display("FAIL bad_count_%0d: got done_seen=%0b at cycle %0d err=%b, want done within 2 cycles err=1",
                 wcs[k], seen, lat, err_seen);
      end
      checks++;
      if (wa_q.size() != 0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_count_nowrite_%0d: got %0d writes busy=%b, want 0 writes busy=0", wcs[k], wa_q.size(), Busy);
      end
    end
  endtask

  task automatic test_jitter_mid_start();
    bit d, e, es, to;
    int n;
    load_scenario1();
    run_load(1'b0, 11'd2, img_xor(), 1, 1, d, e, es, to);
    n = bad_words(1'b0);
    checks++;
    if (to || wa_q.size() != 2 || n != 0 || d !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL jitter_mid_start: got %0d writes %0d wrong done=%b err=%b timeout=%0b, want 2 0 1 0",
               wa_q.size(), n, d, e, to);
    end
  endtask

  task automatic test_reset_mid_load();
    bit d, e, es, to, t1;
    int n;
    load_scenario1();
    @(negedge Fast_Clock);
    Slot = 1'b0;
    Word_Count = 11'd2;
    Start = 1'b1;
    @(negedge Fast_Clock);
    Start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(img[i], t1);
    Reset = 1'b1;
    @(negedge Fast_Clock);
    checks++;
    if ({Byte_Ready, Mem_Write_En, Busy, Done, Error} !== 5'b0 ||
        Mem_Address !== 13'd0 || Mem_Write_Data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_load: got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h, want all 0",
               Byte_Ready, Mem_Write_En, Busy, Done, Error, Mem_Address, Mem_Write_Data);
    end
    Reset = 1'b0;
    run_load(1'b0, 11'd2, img_xor(), 0, 0, d, e, es, to);
    n = bad_words(1'b0);
    checks++;
    if (to || wa_q.size() != 2 || n != 0 || d !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_reset: got %0d writes %0d wrong done=%b err=%b, want 2 0 1 0", wa_q.size(), n, d, e);
    end
  endtask

  task automatic test_full_slot();
    bit d, e, es, to;
    int n;
    img.delete();
    for (int i = 0; i < 4096; i++) img.push_back(8'(i * 7 + 3));
    run_load(1'b1, 11'd1024, img_xor(), 0, 0, d, e, es, to);
    n = bad_words(1'b1);
    checks++;
    if (to || wa_q.size() != 1024 || n != 0) begin
      errors++;
      $display("FAIL full_slot_writes: got %0d writes %0d wrong timeout=%0b, want 1024 0", wa_q.size(), n, to);
    end
    checks++;
    if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 13'd2047 || d !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL full_slot_last: got last_addr=%0d done=%b err=%b, want 2047 1 0",
               (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 13'h0, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_slot1();
    test_bad_cksum();
    test_bad_count();
    test_jitter_mid_start();
    test_reset_mid_load();
    test_full_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
